// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encodings,
// default frame geometry and the timer-width helper.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRIG = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    localparam int FRAME_BITS_DEF  = 10;
    localparam int BIT_CYCLES_9600 = 5208;

    // A length of 1 or 2 still needs one counter bit.
    function automatic int timer_width(input int len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester and serializer-side signals of uart_tx_arb.
// slave = arbiter view, master = requesters/serializer view.
interface uart_tx_arb_if;

    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       tx_trig;
    logic [7:0] tx_data;
    logic       busy;
    logic       grant_id;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, tx_trig, tx_data, busy, grant_id
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, tx_trig, tx_data, busy, grant_id
    );

endinterface

// File: rtl/uart_frame_timer.sv
// Frame timer: counts up from 0 while enabled, tc flags the last cycle of
// a LEN-cycle window. Saturates at the terminal value so it never wraps.
module uart_frame_timer
    import uart_pkg::*;
#(
    parameter int LEN = 40
) (
    input  logic sclk,
    input  logic s_rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int             W      = timer_width(LEN);
    localparam logic [W-1:0]   TC_VAL = W'(LEN - 1);

    logic [W-1:0] count;

    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != TC_VAL) begin
            count <= count + 1'b1;
        end
    end

    assign tc = enable && (count == TC_VAL);

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx serializer between two byte requesters.
// Define UART_TX_ARB_FIXED_PRIO_EN for strict requester-0 priority instead.
//
// state   | meaning
// IDLE    | arbitrating; a ready is raised for the winning valid requester
// TRIG    | one-cycle tx_trig to the serializer, frame timer cleared
// WAIT    | frame timer running; all requesters held off
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES = BIT_CYCLES_9600,
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int GAP_CYCLES = 0
) (
    input  logic         sclk,
    input  logic         s_rst_n,
    uart_tx_arb_if.slave bus
);

    localparam int FRAME_LEN = BIT_CYCLES * FRAME_BITS + GAP_CYCLES;

    arb_state_t state, state_nxt;
    logic       last_grant;
    logic       rdy0, rdy1;
    logic       timer_clr, timer_en, timer_tc;

    always_comb begin
        state_nxt = state;
        rdy0      = 1'b0;
        rdy1      = 1'b0;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        case (state)
            ST_IDLE: begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
                rdy0 = bus.req0_valid;
                rdy1 = bus.req1_valid & !bus.req0_valid;
`else
                rdy0 = bus.req0_valid & (!bus.req1_valid | last_grant);
                rdy1 = bus.req1_valid & (!bus.req0_valid | !last_grant);
`endif
                if (rdy0 || rdy1) begin
                    state_nxt = ST_TRIG;
                end
            end
            ST_TRIG: begin
                timer_clr = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                timer_en = 1'b1;
                if (timer_tc) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Readys are combinational, so they must not leak out while in reset.
        if (!s_rst_n) begin
            rdy0 = 1'b0;
            rdy1 = 1'b0;
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;

    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            state        <= ST_IDLE;
            bus.tx_trig  <= 1'b0;
            bus.tx_data  <= 8'h00;
            bus.busy     <= 1'b0;
            bus.grant_id <= 1'b0;
            last_grant   <= 1'b1;
        end else begin
            state       <= state_nxt;
            bus.tx_trig <= rdy0 | rdy1;
            if (rdy0) begin
                bus.tx_data  <= bus.req0_data;
                bus.grant_id <= 1'b0;
                last_grant   <= 1'b0;
                bus.busy     <= 1'b1;
            end else if (rdy1) begin
                bus.tx_data  <= bus.req1_data;
                bus.grant_id <= 1'b1;
                last_grant   <= 1'b1;
                bus.busy     <= 1'b1;
            end else if (state == ST_WAIT && timer_tc) begin
                bus.busy <= 1'b0;
            end
        end
    end

    uart_frame_timer #(
        .LEN (FRAME_LEN)
    ) u_frame_timer (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .clear   (timer_clr),
        .enable  (timer_en),
        .tc      (timer_tc)
    );

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a 40-cycle frame; accepted bytes are
// queued as expectations and popped when tx_trig fires.
module tb_uart_tx_arb;

    localparam int FRAME   = 40;
    localparam int SPACING = FRAME + 2;

    typedef struct packed {
        logic [7:0] data;
        logic       id;
    } sb_t;

    logic sclk = 1'b0;
    logic s_rst_n;

    uart_tx_arb_if bus();

    uart_tx_arb #(
        .BIT_CYCLES (4),
        .FRAME_BITS (10),
        .GAP_CYCLES (0)
    ) dut (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .bus     (bus)
    );

    always #5 sclk = ~sclk;

    sb_t  sb[$];
    int   n_err     = 0;
    int   n_chk     = 0;
    int   n_push    = 0;
    int   trig_seen = 0;
    int   cyc       = 0;
    int   last_trig = 0;
    logic lg;
    logic tie_order [4];

    always @(posedge sclk) cyc++;
    always @(negedge sclk) if (bus.tx_trig === 1'b1) trig_seen++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge sclk);
        #1;
    endtask

    function automatic logic exp_rdy0();
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        return bus.req0_valid;
`else
        return bus.req0_valid & (!bus.req1_valid | lg);
`endif
    endfunction

    function automatic logic exp_rdy1();
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        return bus.req1_valid & !bus.req0_valid;
`else
        return bus.req1_valid & (!bus.req0_valid | !lg);
`endif
    endfunction

    // Called in an idle cycle with inputs settled; checks readys each cycle
    // until a grant, then queues the expected byte/owner.
    task automatic wait_accept(input string tag, input logic exp_id, input int max);
        bit   done;
        sb_t  e;
        logic winner;
        done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            if (i != 0) step();
            check({tag, "_rdy0"}, bus.req0_ready, exp_rdy0());
            check({tag, "_rdy1"}, bus.req1_ready, exp_rdy1());
            if ((bus.req0_ready & bus.req0_valid) || (bus.req1_ready & bus.req1_valid)) begin
                winner = bus.req1_ready;
                check({tag, "_winner"}, winner, exp_id);
                e.id   = exp_id;
                e.data = exp_id ? bus.req1_data : bus.req0_data;
                sb.push_back(e);
                n_push++;
                lg   = exp_id;
                done = 1'b1;
            end
        end
        check({tag, "_accepted"}, done, 1);
    endtask

    // Runs from the accept cycle N through N+42 (or an injected reset).
    task automatic expect_frame(input string tag, input bit drop, input int raise1_at, input int rst_at);
        sb_t e;
        step();
        check({tag, "_sb_depth"}, sb.size(), 1);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        check({tag, "_trig"}, bus.tx_trig, 1);
        check({tag, "_data"}, bus.tx_data, e.data);
        check({tag, "_gid"}, bus.grant_id, e.id);
        check({tag, "_busy_set"}, bus.busy, 1);
        last_trig = cyc;
        if (drop) begin
            if (e.id) bus.req1_valid = 1'b0;
            else      bus.req0_valid = 1'b0;
        end
        for (int k = 2; k <= FRAME + 1; k++) begin
            @(negedge sclk);
            if (k == raise1_at) begin
                bus.req1_valid = 1'b1;
                bus.req1_data  = 8'hF0;
            end
            #1;
            check({tag, "_trig_low"}, bus.tx_trig, 0);
            check({tag, "_busy"}, bus.busy, 1);
            check({tag, "_hold"}, bus.tx_data, e.data);
            check({tag, "_wait_rdy0"}, bus.req0_ready, 0);
            check({tag, "_wait_rdy1"}, bus.req1_ready, 0);
            if (k == rst_at) begin
                s_rst_n = 1'b0;
                @(negedge sclk);
                s_rst_n = 1'b1;
                #1;
                lg = 1'b1;
                check({tag, "_rst_busy"}, bus.busy, 0);
                check({tag, "_rst_trig"}, bus.tx_trig, 0);
                check({tag, "_rst_data"}, bus.tx_data, 8'h00);
                check({tag, "_rst_gid"}, bus.grant_id, 0);
                return;
            end
        end
        step();
        check({tag, "_busy_clr"}, bus.busy, 0);
        check({tag, "_trig_end"}, bus.tx_trig, 0);
    endtask

    initial begin
        int prev;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        tie_order[0] = 1'b0; tie_order[1] = 1'b0; tie_order[2] = 1'b0; tie_order[3] = 1'b0;
`else
        tie_order[0] = 1'b0; tie_order[1] = 1'b1; tie_order[2] = 1'b0; tie_order[3] = 1'b1;
`endif
        lg             = 1'b1;
        s_rst_n        = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'hA5;
        bus.req1_valid = 1'b0;
        bus.req1_data  = 8'h00;

        repeat (5) begin
            step();
            check("rst_rdy0", bus.req0_ready, 0);
            check("rst_trig", bus.tx_trig, 0);
            check("rst_data", bus.tx_data, 8'h00);
            check("rst_busy", bus.busy, 0);
            check("rst_gid", bus.grant_id, 0);
        end

        // Release reset with both requesters valid: tie sequence.
        @(negedge sclk);
        s_rst_n        = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h3C;
        #1;
        check("rel_rdy0", bus.req0_ready, 1);
        for (int i = 0; i < 4; i++) begin
            wait_accept("tie", tie_order[i], 3);
            prev = last_trig;
            expect_frame("tie", 1'b0, 0, 0);
            if (i > 0) check("tie_spacing", last_trig - prev, SPACING);
        end

        // Drop both valids while a ready is up: nothing must be granted.
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        check("drop_rdy0", bus.req0_ready, 0);
        check("drop_rdy1", bus.req1_ready, 0);
        step();
        check("drop_trig", bus.tx_trig, 0);
        check("drop_busy", bus.busy, 0);

        // Single byte from requester 0; requester 1 arrives mid-frame.
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h55;
        #1;
        wait_accept("single", 1'b0, 2);
        expect_frame("single", 1'b1, 10, 0);
        wait_accept("holdoff", 1'b1, 1);
        expect_frame("holdoff", 1'b1, 0, 0);

        // Reset at timer=20, then a fresh full frame.
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h99;
        #1;
        wait_accept("mid", 1'b0, 2);
        expect_frame("mid", 1'b1, 0, 22);
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h12;
        #1;
        wait_accept("fresh", 1'b0, 2);
        expect_frame("fresh", 1'b1, 0, 0);

        step();
        check("trig_count", trig_seen, n_push);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
